// File: rtl/alu_if.sv
// Operand/result handshake bundle for alu_pipe: request beat in, result beat
// out, plus the sticky overflow status/clear pair.
interface alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_carry;
    logic             out_ovf;
    logic             out_cmp;
    logic             clr_sticky;
    logic             sticky_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_cin, out_ready, clr_sticky,
        output in_ready, out_valid, out_result, out_zero, out_carry, out_ovf,
               out_cmp, sticky_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_cin, out_ready, clr_sticky,
        input  in_ready, out_valid, out_result, out_zero, out_carry, out_ovf,
               out_cmp, sticky_ovf
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU: S1 holds the accepted operands, S2 holds
// the computed result and flags. Valid/ready on both sides, sticky overflow.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);
    localparam int M = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000, OP_SUB = 3'b001, OP_NOT = 3'b010, OP_AND = 3'b011,
        OP_OR  = 3'b100, OP_XOR = 3'b101, OP_SLT = 3'b110, OP_EQ  = 3'b111
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        op_e              op;
        logic             cin;
    } req_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             carry;
        logic             ovf;
        logic             cmp;
    } rsp_t;

    req_t       s1, req;
    rsp_t       s2, rsp_d;
    logic [2:1] vld_pipe;
    logic       s2_adv;
    logic       sticky;
    logic [WIDTH:0] add_sum, sub_sum;
    logic       add_ovf, sub_ovf, lt, eq;

    assign s2_adv       = !vld_pipe[2] || bus.out_ready;
    assign bus.in_ready = !vld_pipe[1] || s2_adv;

    assign req = '{a: bus.in_a, b: bus.in_b, op: op_e'(bus.in_op), cin: bus.in_cin};

    // Both sums are kept WIDTH+1 wide so the carry survives into the flags.
    always_comb begin
        add_sum = {1'b0, s1.a} + {1'b0, s1.b} + {{WIDTH{1'b0}}, s1.cin};
        sub_sum = {1'b0, s1.a} + {1'b0, ~s1.b} + {{WIDTH{1'b0}}, 1'b1};
        add_ovf = (s1.a[M] == s1.b[M]) && (add_sum[M] != s1.a[M]);
        sub_ovf = (s1.a[M] != s1.b[M]) && (sub_sum[M] != s1.a[M]);
        lt      = sub_sum[M] ^ sub_ovf;
        eq      = (s1.a == s1.b);
    end

    always_comb begin
        rsp_d = '0;
        case (s1.op)
            OP_ADD: begin
                rsp_d.result = add_sum[M:0];
                rsp_d.carry  = add_sum[WIDTH];
                rsp_d.ovf    = add_ovf;
            end
            OP_SUB: begin
                rsp_d.result = sub_sum[M:0];
                rsp_d.carry  = sub_sum[WIDTH];
                rsp_d.ovf    = sub_ovf;
            end
            OP_NOT: rsp_d.result = ~s1.a;
            OP_AND: rsp_d.result = s1.a & s1.b;
            OP_OR:  rsp_d.result = s1.a | s1.b;
            OP_XOR: rsp_d.result = s1.a ^ s1.b;
            OP_SLT: begin
                rsp_d.result = {{M{1'b0}}, lt};
                rsp_d.cmp    = lt;
            end
            OP_EQ: begin
                rsp_d.result = {{M{1'b0}}, eq};
                rsp_d.cmp    = eq;
            end
            default: rsp_d = '0;
        endcase
        rsp_d.zero = (rsp_d.result == '0);
    end

    // S1 reloads whenever it is empty or draining into S2 this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1       <= '0;
            s2       <= '0;
            sticky   <= 1'b0;
        end else begin
            if (bus.in_ready) begin
                vld_pipe[1] <= bus.in_valid;
                if (bus.in_valid) s1 <= req;
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) s2 <= rsp_d;
            end
            if (bus.out_valid && bus.out_ready && s2.ovf) sticky <= 1'b1;
            else if (bus.clr_sticky)                      sticky <= 1'b0;
        end
    end

    assign bus.out_valid  = vld_pipe[2];
    assign bus.out_result = s2.result;
    assign bus.out_zero   = s2.zero;
    assign bus.out_carry  = s2.carry;
    assign bus.out_ovf    = s2.ovf;
    assign bus.out_cmp    = s2.cmp;
    assign bus.sticky_ovf = sticky;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8: expected results are queued on
// acceptance and compared in order as result beats are delivered.
module tb_alu_pipe;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_if #(.WIDTH(W)) bus();
    alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         v;
        logic         cmp;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic [2:0] op, logic cin);
        exp_t e;
        int   s, sa, sb, ci, ss;
        e  = '0;
        sa = $signed(a);
        sb = $signed(b);
        ci = int'(cin);
        case (op)
            3'd0: begin
                s   = int'(a) + int'(b) + ci;
                e.r = s[7:0];
                e.c = s[8];
                ss  = sa + sb + ci;
                e.v = (ss > 127) || (ss < -128);
            end
            3'd1: begin
                e.r = a - b;
                e.c = (a >= b);
                ss  = sa - sb;
                e.v = (ss > 127) || (ss < -128);
            end
            3'd2: e.r = ~a;
            3'd3: e.r = a & b;
            3'd4: e.r = a | b;
            3'd5: e.r = a ^ b;
            3'd6: begin
                e.cmp = (sa < sb);
                e.r   = {7'd0, e.cmp};
            end
            default: begin
                e.cmp = (a == b);
                e.r   = {7'd0, e.cmp};
            end
        endcase
        e.z = (e.r == 8'd0);
        return e;
    endfunction

    // Inputs change just after posedge; handshakes are sampled on negedge.
    always @(negedge clk) begin
        exp_t e, got;
        if (mon_en && !rst) begin
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.in_a, bus.in_b, bus.in_op, bus.in_cin));
            if (bus.out_valid && bus.out_ready) begin
                got = {bus.out_result, bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_cmp};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_extra: got r=%h z%b c%b v%b cmp%b, required no beat",
                             got.r, got.z, got.c, got.v, got.cmp);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL scoreboard: got r=%h z%b c%b v%b cmp%b, required r=%h z%b c%b v%b cmp%b",
                                 got.r, got.z, got.c, got.v, got.cmp, e.r, e.z, e.c, e.v, e.cmp);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic cin);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_cin   = cin;
    endtask

    task automatic drain();
        int n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            cyc();
            n++;
        end
        cyc();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", q.size());
        end
    endtask

    task automatic test_reset();
        mon_en         = 1'b0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.in_op      = '0;
        bus.in_cin     = 1'b0;
        bus.out_ready  = 1'b1;
        bus.clr_sticky = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        checks++;
        if (bus.out_result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h required 00", bus.out_result); end
        checks++;
        if ({bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_cmp} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000", {bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_cmp});
        end
        checks++;
        if (bus.sticky_ovf !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b required 0", bus.sticky_ovf); end
        mon_en = 1'b1;
    endtask

    // ADD 7F+01 overflows; checks two-stage latency and sticky set on delivery.
    task automatic test_latency();
        cyc();
        drive(8'h7F, 8'h01, 3'd0, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: out_valid got %b required 0", bus.out_valid); end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL latency_due: out_valid got %b required 1", bus.out_valid); end
        cyc();
        checks++;
        if (bus.sticky_ovf !== 1'b1) begin errors++; $display("FAIL sticky_set: got %b required 1", bus.sticky_ovf); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL latency_single: out_valid got %b required 0", bus.out_valid); end
    endtask

    task automatic test_directed();
        logic [7:0] va[12] = '{8'h00, 8'h80, 8'hFE, 8'h80, 8'h5A, 8'hFF, 8'h0F, 8'hF0, 8'hF0, 8'hAA, 8'h01, 8'h5A};
        logic [7:0] vb[12] = '{8'h01, 8'h01, 8'h01, 8'h7F, 8'h5A, 8'h01, 8'h00, 8'h3C, 8'h0F, 8'hFF, 8'hFE, 8'h5B};
        logic [2:0] vo[12] = '{3'd1,  3'd1,  3'd6,  3'd6,  3'd7,  3'd0,  3'd2,  3'd3,  3'd4,  3'd5,  3'd6,  3'd7};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(va[i], vb[i], vo[i], (i == 5));
            cyc();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom));
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: beat %0d got %b required 1", i, bus.in_ready); end
            if (i >= 2) begin
                checks++;
                if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_bubble: beat %0d out_valid got %b required 1", i, bus.out_valid); end
            end
            cyc();
        end
        drain();
    endtask

    task automatic test_backpressure();
        int accepts = 0;
        bit snap_ok = 1'b0;
        logic [11:0] snap;
        bus.out_ready = 1'b0;
        drive(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (!snap_ok) begin
                    snap    = {bus.out_result, bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_cmp};
                    snap_ok = 1'b1;
                end else begin
                    checks++;
                    if ({bus.out_result, bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_cmp} !== snap) begin
                        errors++;
                        $display("FAIL stall_stable: cycle %0d got %h required %h", i,
                                 {bus.out_result, bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_cmp}, snap);
                    end
                end
            end
            if (bus.in_ready) begin
                accepts++;
                cyc();
                drive(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom));
            end else begin
                cyc();
            end
        end
        checks++;
        if (accepts != 2) begin errors++; $display("FAIL stall_accepts: got %0d required 2", accepts); end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b required 0", bus.in_ready); end
        // Release: the held beat goes in on the same edge S2 drains.
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b required 1", bus.in_ready); end
        cyc();
        drain();
    endtask

    task automatic test_sticky_reset();
        bus.clr_sticky = 1'b1;
        cyc();
        checks++;
        if (bus.sticky_ovf !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b required 0", bus.sticky_ovf); end
        bus.out_ready = 1'b1;
        drive(8'h80, 8'h01, 3'd1, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        checks++;
        if (bus.sticky_ovf !== 1'b1) begin errors++; $display("FAIL sticky_set_wins: got %b required 1", bus.sticky_ovf); end
        bus.clr_sticky = 1'b0;

        bus.out_ready = 1'b0;
        drive(8'h12, 8'h34, 3'd0, 1'b0);
        cyc();
        drive(8'h56, 8'h78, 3'd5, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b required 0", bus.in_ready); end
        #1;
        mon_en = 1'b0;
        rst    = 1'b1;
        q.delete();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
        checks++;
        if (bus.out_result !== 8'h00) begin errors++; $display("FAIL rst_result: got %h required 00", bus.out_result); end
        checks++;
        if ({bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_cmp} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_flags: got %b required 0000", {bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_cmp});
        end
        checks++;
        if (bus.sticky_ovf !== 1'b0) begin errors++; $display("FAIL rst_sticky: got %b required 0", bus.sticky_ovf); end
        cyc();
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b required 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        cyc();
        drive(8'h00, 8'h01, 3'd1, 1'b0);
        cyc();
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_sticky_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
